// File: rtl/uart_pkg.sv
// Shared UART definitions: default payload width, transmit FSM state
// encoding and the parity helper also used by the receive parity checker.
package uart_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Widest payload the parity helper accepts; narrower payloads are
    // zero-extended, which leaves the XOR reduction unchanged.
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // typ=1: parity = ^data, typ=0: parity = ~^data
    function automatic logic par_bit(input logic [PAR_MAX_W-1:0] data,
                                     input logic                 typ);
        return typ ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Transmit sequencer: frame state register, data bit counter, busy/ready.
// UART_TX_BUF_EN selects ready from the holding-buffer occupancy.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             par_en,
    input  logic             buf_full,
    output tx_state_e        state,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next-state and bit counter sequencing through the frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go) state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: state_d = STOP;
            STOP:   state_d = go ? START : IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // tx_out lags the state by one register, so busy lags it identically
    always_comb begin
        busy_d = (state_q != IDLE);
    end

    // Request acceptance window
    always_comb begin
`ifdef UART_TX_BUF_EN
        ready = ~buf_full;
`else
        // Also low in the single cycle between accept and the start bit,
        // before busy has risen, so a second request cannot slip in.
        ready = ~buf_full & ~busy_q & (state_q == IDLE);
`endif
    end

    // State, counter and busy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;
    assign busy  = busy_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start(0), data LSB first, optional parity, stop(1).
// Define UART_TX_BUF_EN for a one-entry holding buffer giving back-to-back
// frames; undefined, requests while busy are ignored.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  PAR_en,
    input  logic                  PAR_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  ready
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  go;
    logic                  buf_full;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_out_q, tx_out_d;

    assign accept = data_valid & ready;

`ifdef UART_TX_BUF_EN
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_en_q, buf_en_d;
    logic                  buf_typ_q, buf_typ_d;
    logic                  buf_full_q, buf_full_d;

    // A frame launches from IDLE or from STOP; a buffered payload has
    // priority over the live request.
    assign go       = ((state == IDLE) || (state == STOP)) && (buf_full_q || accept);
    assign buf_full = buf_full_q;

    // Active-frame latch and holding buffer update
    always_comb begin
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        buf_data_d = buf_data_q;
        buf_en_d   = buf_en_q;
        buf_typ_d  = buf_typ_q;
        buf_full_d = buf_full_q;
        if (go) begin
            if (buf_full_q) begin
                data_d     = buf_data_q;
                par_en_d   = buf_en_q;
                par_typ_d  = buf_typ_q;
                buf_full_d = 1'b0;
            end else begin
                data_d    = p_data;
                par_en_d  = PAR_en;
                par_typ_d = PAR_typ;
            end
        end
        // An accept that is not launched straight into the frame lands in
        // the buffer; this covers the same-edge drain-and-refill case.
        if (accept && !(go && !buf_full_q)) begin
            buf_data_d = p_data;
            buf_en_d   = PAR_en;
            buf_typ_d  = PAR_typ;
            buf_full_d = 1'b1;
        end
    end

    // Holding buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_q <= '0;
            buf_en_q   <= 1'b0;
            buf_typ_q  <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_en_q   <= buf_en_d;
            buf_typ_q  <= buf_typ_d;
            buf_full_q <= buf_full_d;
        end
    end
`else
    assign go       = (state == IDLE) && accept;
    assign buf_full = 1'b0;

    // Active-frame latch, loaded only on accept from IDLE
    always_comb begin
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        if (go) begin
            data_d    = p_data;
            par_en_d  = PAR_en;
            par_typ_d = PAR_typ;
        end
    end
`endif

    uart_tx_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .par_en   (par_en_q),
        .buf_full (buf_full),
        .state    (state),
        .cnt      (cnt),
        .busy     (busy),
        .ready    (ready)
    );

    // Serial line value selected by the current frame position
    always_comb begin
        tx_out_d = 1'b1;
        case (state)
            IDLE:    tx_out_d = 1'b1;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = data_q[cnt];
            PARITY:  tx_out_d = par_bit(PAR_MAX_W'(data_q), par_typ_q);
            STOP:    tx_out_d = 1'b1;
            default: tx_out_d = 1'b1;
        endcase
    end

    // Active-frame config and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_out_q  <= 1'b1;
        end else begin
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_out_q  <= tx_out_d;
        end
    end

    assign tx_out = tx_out_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: bit-queue line model checked every cycle, plus
// literal frame expectations. Honours UART_TX_BUF_EN.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       PAR_en;
    logic       PAR_typ;
    logic       tx_out;
    logic       busy;
    logic       ready;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .PAR_en     (PAR_en),
        .PAR_typ    (PAR_typ),
        .tx_out     (tx_out),
        .busy       (busy),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line model ----------------
    bit       line[$];          // frame bits still to appear on tx_out
    bit       pend;             // a frame starts at the next edge
    bit [7:0] pend_d;
    bit       pend_en, pend_typ;
    bit       bfull;
    bit [7:0] b_d;
    bit       b_en, b_typ;
    bit       exp_tx = 1'b1;
    bit       exp_busy;
    bit       model_ok;

    function automatic void push_frame(input bit [7:0] d, input bit en, input bit typ);
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(d[i]);
        if (en) line.push_back(typ ? (^d) : (~^d));
        line.push_back(1'b1);
    endfunction

    function automatic bit m_ready();
`ifdef UART_TX_BUF_EN
        return !bfull;
`else
        return (line.size() == 0) && !pend && !exp_busy;
`endif
    endfunction

    always @(posedge clk) begin
        bit acc, go;
        if (rst === 1'b1) begin
            line.delete();
            pend     = 1'b0;
            bfull    = 1'b0;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = (data_valid === 1'b1) && m_ready();
`ifdef UART_TX_BUF_EN
            // a new frame may begin once only the stop bit (or nothing) remains
            go = !pend && (line.size() <= 1) && (bfull || acc);
`else
            go = acc;
`endif
            if (pend) begin
                push_frame(pend_d, pend_en, pend_typ);
                pend = 1'b0;
            end
            if (line.size() > 0) begin
                exp_tx   = line.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            if (go) begin
                pend = 1'b1;
                if (bfull) begin
                    pend_d = b_d; pend_en = b_en; pend_typ = b_typ;
                    bfull  = 1'b0;
                    if (acc) begin
                        b_d = p_data; b_en = PAR_en; b_typ = PAR_typ; bfull = 1'b1;
                    end
                end else begin
                    pend_d = p_data; pend_en = PAR_en; pend_typ = PAR_typ;
                end
            end else if (acc) begin
                b_d = p_data; b_en = PAR_en; b_typ = PAR_typ; bfull = 1'b1;
            end
        end
    end

    // Single compare process against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_tx",    32'(tx_out), 32'(exp_tx));
            check("model_busy",  32'(busy),   32'(exp_busy));
            check("model_ready", 32'(ready),  32'(m_ready()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic send_capture(input logic [7:0] d, input logic en, input logic typ,
                                input int nbits, output logic [10:0] cap, output int bcnt);
        wait_ready();
        p_data = d; PAR_en = en; PAR_typ = typ; data_valid = 1'b1;
        step();
        // scramble inputs after accept: the frame in flight must not change
        data_valid = 1'b0; p_data = ~d; PAR_en = ~en; PAR_typ = ~typ;
        cap  = '0;
        bcnt = 0;
        for (int i = 0; i < nbits; i++) begin
            step();
            cap = {cap[9:0], tx_out};
            if (busy === 1'b1) bcnt++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy === 1'b1) bcnt++;
        end
    endtask

    logic rec_tx[70];
    logic rec_busy[70];
    logic rec_rdy[70];

    function automatic int find_start(input int from);
        for (int i = from; i < 70; i++)
            if (rec_busy[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic logic [10:0] get_frame(input int s);
        logic [10:0] f = '1;
        if (s < 0 || s + 10 >= 70) return f;
        for (int i = 0; i < 11; i++) f = {f[9:0], rec_tx[s+i]};
        return f;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [10:0] cap;
        int          bc;
        int          stage;
        int          s2, s3;
        bit          acc;

        rst = 1'b1; data_valid = 1'b0; p_data = '0; PAR_en = 1'b0; PAR_typ = 1'b0;
        step();
        check("reset_tx",    32'(tx_out), 32'd1);
        check("reset_busy",  32'(busy),   32'd0);
        check("reset_ready", 32'(ready),  32'd1);
        step();
        rst = 1'b0;
        step();

        send_capture(8'h56, 1'b1, 1'b1, 11, cap, bc);
        check("frame_56", 32'(cap), 32'(11'b00110101001));
        check("busy_56",  32'(bc),  32'd11);

        send_capture(8'h32, 1'b1, 1'b0, 11, cap, bc);
        check("frame_32", 32'(cap), 32'(11'b00100110001));
        check("busy_32",  32'(bc),  32'd11);

        send_capture(8'hF0, 1'b0, 1'b0, 10, cap, bc);
        check("frame_F0", 32'(cap), 32'(11'b00000011111));
        check("busy_F0",  32'(bc),  32'd10);

        // reset in the middle of a frame
        wait_ready();
        p_data = 8'h56; PAR_en = 1'b1; PAR_typ = 1'b1; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midrst_tx",    32'(tx_out), 32'd1);
        check("midrst_busy",  32'(busy),   32'd0);
        check("midrst_ready", 32'(ready),  32'd1);
        step();
        rst = 1'b0;
        send_capture(8'h32, 1'b1, 1'b0, 11, cap, bc);
        check("post_rst_frame", 32'(cap), 32'(11'b00100110001));
        check("post_rst_busy",  32'(bc),  32'd11);

        // held request stream: 01, then 80, then A5
        wait_ready();
        p_data = 8'h01; PAR_en = 1'b1; PAR_typ = 1'b1; data_valid = 1'b1;
        step();
        p_data = 8'h80;
        stage  = 0;
        for (int i = 0; i < 70; i++) begin
            rec_tx[i]   = tx_out;
            rec_busy[i] = busy;
            rec_rdy[i]  = ready;
            acc = (ready === 1'b1) && (data_valid === 1'b1);
            step();
            if (acc) begin
                stage++;
                if (stage == 1) p_data = 8'hA5;
                else data_valid = 1'b0;
            end
        end
        data_valid = 1'b0;
        s2 = find_start(12);
        s3 = (s2 >= 0) ? find_start(s2 + 11) : -1;
        check("seq_frame_01", 32'(get_frame(1)),  32'(11'b01000000011));
        check("seq_frame_80", 32'(get_frame(s2)), 32'(11'b00000000111));
        check("seq_frame_A5", 32'(get_frame(s3)), 32'(11'b01010010101));
        check("seq_ready_busy", 32'(rec_rdy[5]), 32'd0);
`ifdef UART_TX_BUF_EN
        check("b2b_gap_12",   32'(s2 - 12),        32'd0);
        check("b2b_gap_23",   32'(s3 - (s2 + 11)), 32'd0);
        check("buf_full_rdy", 32'(rec_rdy[1]),     32'd0);
`else
        check("idle_gap_12",  32'((s2 - 12) >= 1),        32'd1);
        check("idle_gap_23",  32'((s3 - (s2 + 11)) >= 1), 32'd1);
`endif
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
